// File: rtl/bch_pkg.sv
// Shared BCH(15,7,2) constants, GF(16) arithmetic helpers and receive FSM state type.
package bch_pkg;

  localparam int unsigned BCH_N = 15;
  localparam int unsigned BCH_K = 7;
  localparam logic [8:0]  GEN_MASK  = 9'b111010001;
  localparam logic [4:0]  GF16_POLY = 5'b10011;

  typedef logic [3:0] gf16;

  typedef enum logic {IDLE, SHIFT} bch_rx_state_e;

  function automatic gf16 gf16_mul_alpha(input gf16 a);
    gf16 r;
    r = {a[2:0], 1'b0};
    if (a[3]) r = r ^ GF16_POLY[3:0];
    return r;
  endfunction

  // Columns are alpha^3..alpha^6 reduced mod x^4+x+1
  function automatic gf16 gf16_mul_alpha3(input gf16 a);
    return {a[0] ^ a[3], a[2] ^ a[3], a[1] ^ a[2], a[1]};
  endfunction

endpackage

// File: rtl/bch_syndrome_accum.sv
// One Horner syndrome accumulator: acc = acc*alpha^k xor bit, with k = 1 or 3.
module bch_syndrome_accum
  import bch_pkg::*;
#(
  parameter bit USE_ALPHA3 = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_bit,
  output gf16  o_acc
);

  gf16 r_acc;
  gf16 w_mul;

  assign w_mul = USE_ALPHA3 ? gf16_mul_alpha3(r_acc) : gf16_mul_alpha(r_acc);

  // Clear and first bit share one cycle: the frame's first bit seeds the accumulator
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_acc <= '0;
    else if (i_en) r_acc <= (i_clr ? 4'b0000 : w_mul) ^ {3'b000, i_bit};
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/bch_rx_frame_deserializer.sv
// Serial BCH(15,7) receive front end with a one-entry output buffer.
// Define BCH_RX_SYNDROME_EN to compute S1/S3 on the fly; otherwise they read as zero.
module bch_rx_frame_deserializer
  import bch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bit_in,
  input  logic          bit_valid,
  input  logic          frame_start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [14:0]   codeword,
  output logic [3:0]    s1,
  output logic [3:0]    s3,
  output logic          syndrome_zero,
  output logic          overrun
);

  localparam int unsigned N = BCH_N;

  bch_rx_state_e r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [N-1:0]  r_sh, w_sh_nxt;
  logic          w_start, w_done;
  logic          r_load_pend;
  logic          r_out_valid, r_overrun;
  logic [N-1:0]  r_codeword;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_sh;
    w_start     = 1'b0;
    w_done      = 1'b0;
    if (bit_valid) begin
      if (frame_start) begin
        w_start     = 1'b1;
        w_state_nxt = SHIFT;
        w_cnt_nxt   = 4'd1;
        w_sh_nxt    = {{(N-1){1'b0}}, bit_in};
      end else if (r_state == SHIFT) begin
        w_sh_nxt = {r_sh[N-2:0], bit_in};
        if (r_cnt == 4'(N-1)) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_load_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sh        <= w_sh_nxt;
      r_load_pend <= w_done;
    end
  end

  // Completed frame sits in r_sh/accumulators for one cycle, then moves to the buffer
  logic w_load;
  assign w_load = r_load_pend && (!r_out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_codeword  <= '0;
    end else begin
      r_overrun <= r_load_pend && !w_load;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_codeword  <= r_sh;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign codeword  = r_codeword;

`ifdef BCH_RX_SYNDROME_EN
  gf16  w_a1, w_a3;
  gf16  r_s1, r_s3;
  logic w_acc_en;

  assign w_acc_en = bit_valid && (frame_start || r_state == SHIFT);

  bch_syndrome_accum #(.USE_ALPHA3(1'b0)) u_acc_s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(w_start), .i_en(w_acc_en),
    .i_bit(bit_in), .o_acc(w_a1)
  );

  bch_syndrome_accum #(.USE_ALPHA3(1'b1)) u_acc_s3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(w_start), .i_en(w_acc_en),
    .i_bit(bit_in), .o_acc(w_a3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s3 <= '0;
    end else if (w_load) begin
      r_s1 <= w_a1;
      r_s3 <= w_a3;
    end
  end

  assign s1            = r_s1;
  assign s3            = r_s3;
  assign syndrome_zero = (r_s1 == 4'd0) && (r_s3 == 4'd0);
`else
  assign s1            = '0;
  assign s3            = '0;
  assign syndrome_zero = 1'b1;
`endif

endmodule

// File: tb/tb_bch_rx_frame_deserializer.sv
// Directed self-checking bench for bch_rx_frame_deserializer.
module tb_bch_rx_frame_deserializer;

  logic        clk;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        frame_start;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] codeword;
  logic [3:0]  s1;
  logic [3:0]  s3;
  logic        syndrome_zero;
  logic        overrun;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bch_rx_frame_deserializer dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .out_valid(out_valid), .out_ready(out_ready),
    .codeword(codeword), .s1(s1), .s3(s3), .syndrome_zero(syndrome_zero),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    bit_in      = b;
    frame_start = fs;
    bit_valid   = 1'b1;
    tick();
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  // Gaps drive noise on bit_in/frame_start with bit_valid low
  task automatic send_frame(input logic [14:0] f, input bit gaps);
    for (int i = 14; i >= 0; i--) begin
      if (gaps && (i % 4 == 1)) begin
        for (int g = 0; g < 2; g++) begin
          bit_in      = 1'($urandom_range(0, 1));
          frame_start = 1'($urandom_range(0, 1));
          bit_valid   = 1'b0;
          tick();
        end
      end
      send_bit(f[i], i == 14);
    end
  endtask

  task automatic check_out(input string tag, input logic [14:0] cw,
                           input logic [3:0] e1, input logic [3:0] e3);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".cw"}, 32'(codeword), 32'(cw));
`ifdef BCH_RX_SYNDROME_EN
    check({tag, ".s1"}, 32'(s1), 32'(e1));
    check({tag, ".s3"}, 32'(s3), 32'(e3));
    check({tag, ".sz"}, 32'(syndrome_zero), 32'((e1 == 4'd0) && (e3 == 4'd0)));
`else
    check({tag, ".s1"}, 32'(s1), 32'd0);
    check({tag, ".s3"}, 32'(s3), 32'd0);
    check({tag, ".sz"}, 32'(syndrome_zero), 32'd1);
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    out_ready   = 1'b1;
    #23;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.ovr", 32'(overrun), 32'd0);
    check("rst.cw", 32'(codeword), 32'd0);
    check("rst.s1", 32'(s1), 32'd0);
    check("rst.s3", 32'(s3), 32'd0);
    check("rst.sz", 32'(syndrome_zero), 32'd1);
    rst_n = 1'b1;
    tick();

    // Valid codeword with latency check
    send_frame(15'h40E8, 1'b0);
    check("lat.valid_early", 32'(out_valid), 32'd0);
    tick();
    check_out("cw40E8", 15'h40E8, 4'd0, 4'd0);
    tick();
    check("cw40E8.xfer", 32'(out_valid), 32'd0);

    // Single-bit errors
    send_frame(15'h0001, 1'b0);
    tick();
    check_out("e0", 15'h0001, 4'd1, 4'd1);
    tick();
    send_frame(15'h4000, 1'b0);
    tick();
    check_out("e14", 15'h4000, 4'd9, 4'd15);
    tick();

    // Back-pressure: second frame dropped with overrun
    out_ready = 1'b0;
    send_frame(15'h0001, 1'b0);
    tick();
    check_out("bp.f1", 15'h0001, 4'd1, 4'd1);
    send_frame(15'h4000, 1'b0);
    tick();
    check("bp.ovr_pulse", 32'(overrun), 32'd1);
    check_out("bp.held", 15'h0001, 4'd1, 4'd1);
    tick();
    check("bp.ovr_end", 32'(overrun), 32'd0);
    check("bp.still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp.xfer", 32'(out_valid), 32'd0);
    tick();
    check("bp.no_second", 32'(out_valid), 32'd0);

    // Release coinciding with load of the next frame
    out_ready = 1'b0;
    send_frame(15'h0001, 1'b0);
    tick();
    send_frame(15'h4000, 1'b0);
    out_ready = 1'b1;
    tick();
    check("sim.ovr", 32'(overrun), 32'd0);
    check_out("sim.f2", 15'h4000, 4'd9, 4'd15);
    tick();
    check("sim.xfer", 32'(out_valid), 32'd0);

    // Resync after 6 bits of a partial frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_frame(15'h4000, 1'b0);
    tick();
    check_out("resync", 15'h4000, 4'd9, 4'd15);
    tick();

    // bit_valid gaps, frame 4001: S1 = 9^1, S3 = 15^1
    send_frame(15'h4001, 1'b1);
    tick();
    check_out("gaps", 15'h4001, 4'd8, 4'd14);
    tick();

    // Reset while output held
    out_ready = 1'b0;
    send_frame(15'h4000, 1'b0);
    tick();
    check("rstv.pre", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstv.valid", 32'(out_valid), 32'd0);
    check("rstv.cw", 32'(codeword), 32'd0);
    check("rstv.sz", 32'(syndrome_zero), 32'd1);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 7; i++) send_bit(1'b1, i == 0);
    #2 rst_n = 1'b0;
    #1;
    check("rstm.valid", 32'(out_valid), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    send_bit(1'b1, 1'b0);
    tick();
    check("rstm.idle_ignore", 32'(out_valid), 32'd0);
    send_frame(15'h0001, 1'b0);
    tick();
    check_out("rstm.f", 15'h0001, 4'd1, 4'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
